// File: rtl/regread_stage.sv
// rtl/regread_stage.sv - register file and operand-read pipeline stage with forwarding, load-use stall and sticky halt
module regread_stage #(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AW-1:0]    in_ra,
    input  logic [AW-1:0]    in_rb,
    input  logic             in_use_a,
    input  logic             in_use_b,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_sel_imm,
    input  logic             in_wr_en,
    input  logic [AW-1:0]    in_wr_addr,
    input  logic             in_is_load,
    input  logic             in_halt,
    input  logic             ex_valid,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_wr_addr,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             mem_valid,
    input  logic             mem_wr_en,
    input  logic [AW-1:0]    mem_wr_addr,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    input  logic [AW-1:0]    dbg_addr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_wr_en,
    output logic [AW-1:0]    out_wr_addr,
    output logic             out_is_load,
    output logic             stall,
    output logic             halted,
    output logic [WIDTH-1:0] dbg_data
);
    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] regs [NREG];
    logic             zero_a, zero_b;
    logic             haz_a, haz_b;
    logic             issue, take_halt;
    logic [WIDTH-1:0] opnd_a, opnd_b;

    // Youngest producer wins; a load in execute has no data yet, so it is skipped here and stalls instead.
    function automatic logic [WIDTH-1:0] resolve(input logic [AW-1:0] ra);
        if (ZERO_REG != 0 && ra == '0)
            return '0;
        else if (ex_valid && ex_wr_en && !ex_is_load && ex_wr_addr == ra)
            return ex_result;
        else if (mem_valid && mem_wr_en && mem_wr_addr == ra)
            return mem_result;
        else if (wb_en && wb_addr == ra)
            return wb_data;
        else
            return regs[ra];
    endfunction

    always_comb begin
        zero_a = (ZERO_REG != 0) && (in_ra == '0);
        zero_b = (ZERO_REG != 0) && (in_rb == '0);
        haz_a  = in_use_a && !zero_a && (ex_wr_addr == in_ra);
        haz_b  = in_use_b && !in_sel_imm && !zero_b && (ex_wr_addr == in_rb);
        stall  = in_valid && !halted && ex_valid && ex_wr_en && ex_is_load && (haz_a || haz_b);
        opnd_a = resolve(in_ra);
        opnd_b = in_sel_imm ? in_imm : resolve(in_rb);
        take_halt = in_valid && in_halt && !stall && !flush && !halted;
        issue     = in_valid && !in_halt && !stall && !flush && !halted;
    end

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_is_load <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (wb_en && !(ZERO_REG != 0 && wb_addr == '0))
                regs[wb_addr] <= wb_data;
            if (take_halt)
                halted <= 1'b1;
            if (issue) begin
                out_valid   <= 1'b1;
                out_a       <= opnd_a;
                out_b       <= opnd_b;
                out_wr_en   <= in_wr_en;
                out_wr_addr <= in_wr_addr;
                out_is_load <= in_is_load;
            end else begin
                out_valid   <= 1'b0;
                out_wr_en   <= 1'b0;
                out_is_load <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regread_stage.sv
// tb/tb_regread_stage.sv - directed self-checking bench for regread_stage (plain and hardwired-zero instances)
module tb_regread_stage;
    localparam int W  = 16;
    localparam int AW = 3;

    logic clock = 1'b0;
    logic reset;
    logic in_valid, in_use_a, in_use_b, in_sel_imm, in_wr_en, in_is_load, in_halt;
    logic [AW-1:0] in_ra, in_rb, in_wr_addr;
    logic [W-1:0]  in_imm;
    logic ex_valid, ex_wr_en, ex_is_load, mem_valid, mem_wr_en, wb_en, flush;
    logic [AW-1:0] ex_wr_addr, mem_wr_addr, wb_addr, dbg_addr;
    logic [W-1:0]  ex_result, mem_result, wb_data;

    logic          v0, we0, ld0, st0, h0, v1, we1, ld1, st1, h1;
    logic [W-1:0]  a0, b0, d0, a1, b1, d1;
    logic [AW-1:0] wa0, wa1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regread_stage #(.WIDTH(W), .AW(AW), .ZERO_REG(0)) u0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ra(in_ra), .in_rb(in_rb),
        .in_use_a(in_use_a), .in_use_b(in_use_b), .in_imm(in_imm), .in_sel_imm(in_sel_imm),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_is_load(in_is_load), .in_halt(in_halt),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_result(mem_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .dbg_addr(dbg_addr), .out_valid(v0), .out_a(a0), .out_b(b0), .out_wr_en(we0),
        .out_wr_addr(wa0), .out_is_load(ld0), .stall(st0), .halted(h0), .dbg_data(d0));

    regread_stage #(.WIDTH(W), .AW(AW), .ZERO_REG(1)) u1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ra(in_ra), .in_rb(in_rb),
        .in_use_a(in_use_a), .in_use_b(in_use_b), .in_imm(in_imm), .in_sel_imm(in_sel_imm),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_is_load(in_is_load), .in_halt(in_halt),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_result(mem_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .dbg_addr(dbg_addr), .out_valid(v1), .out_a(a1), .out_b(b1), .out_wr_en(we1),
        .out_wr_addr(wa1), .out_is_load(ld1), .stall(st1), .halted(h1), .dbg_data(d1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        reset = 0; in_valid = 0; in_ra = '0; in_rb = '0; in_use_a = 0; in_use_b = 0;
        in_imm = '0; in_sel_imm = 0; in_wr_en = 0; in_wr_addr = '0; in_is_load = 0; in_halt = 0;
        ex_valid = 0; ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_result = '0;
        mem_valid = 0; mem_wr_en = 0; mem_wr_addr = '0; mem_result = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; dbg_addr = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear();
        // reset discards a concurrent write
        reset = 1; wb_en = 1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        step();
        clear();
        dbg_addr = 3'd5;
        #1;
        check("rst_out_valid", v0, 0);
        check("rst_halted", h0, 0);
        check("rst_out_a", a0, 0);
        check("rst_dbg_r5", d0, 0);

        wb_en = 1; wb_addr = 3'd3; wb_data = 16'h1234;
        step();
        clear();
        in_valid = 1; in_ra = 3'd3; in_use_a = 1; in_rb = 3'd3; dbg_addr = 3'd3;
        in_wr_en = 1; in_wr_addr = 3'd6;
        #1;
        check("dbg_r3", d0, 16'h1234);
        step();
        check("reg_valid", v0, 1);
        check("reg_a", a0, 16'h1234);
        check("reg_b", b0, 16'h1234);
        check("reg_wr_addr", wa0, 3'd6);

        clear();
        in_valid = 1; in_ra = 3'd2; wb_en = 1; wb_addr = 3'd2; wb_data = 16'h00AA;
        step();
        check("wb_bypass_a", a0, 16'h00AA);

        clear();
        in_valid = 1; in_ra = 3'd1; in_use_a = 1;
        ex_valid = 1; ex_wr_en = 1; ex_wr_addr = 3'd1; ex_result = 16'h0005;
        mem_valid = 1; mem_wr_en = 1; mem_wr_addr = 3'd1; mem_result = 16'h0009;
        step();
        check("fwd_ex_a", a0, 16'h0005);
        ex_valid = 0;
        step();
        check("fwd_mem_a", a0, 16'h0009);

        clear();
        in_valid = 1; in_rb = 3'd4; in_use_b = 1; in_wr_en = 1; in_wr_addr = 3'd7;
        ex_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3'd4;
        #1;
        check("loaduse_stall", st0, 1);
        step();
        check("loaduse_valid", v0, 0);
        check("loaduse_wr_en", we0, 0);
        flush = 1;
        #1;
        check("flush_stall_seen", st0, 1);
        step();
        check("flush_valid", v0, 0);
        flush = 0; in_sel_imm = 1; in_imm = 16'hFFF0;
        #1;
        check("imm_no_stall", st0, 0);
        step();
        check("imm_valid", v0, 1);
        check("imm_b", b0, 16'hFFF0);
        check("imm_wr_en", we0, 1);
        check("imm_wr_addr", wa0, 3'd7);

        clear();
        wb_en = 1; wb_addr = 3'd0; wb_data = 16'h7777;
        step();
        clear();
        in_valid = 1; in_ra = 3'd0; in_use_a = 1;
        ex_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3'd0;
        #1;
        check("z_stall", st1, 0);
        check("nz_stall", st0, 1);
        check("z_dbg_r0", d1, 0);
        check("nz_dbg_r0", d0, 16'h7777);
        step();
        check("z_valid", v1, 1);
        check("z_a", a1, 0);
        check("nz_valid", v0, 0);

        clear();
        in_valid = 1; in_halt = 1; flush = 1;
        step();
        check("halt_flushed", h0, 0);
        flush = 0;
        step();
        check("halt_set", h0, 1);
        check("halt_valid", v0, 0);
        clear();
        in_valid = 1; in_ra = 3'd3; in_use_a = 1;
        ex_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3'd3;
        wb_en = 1; wb_addr = 3'd6; wb_data = 16'h0606;
        #1;
        check("halted_no_stall", st0, 0);
        step();
        check("halted_valid", v0, 0);
        check("halted_sticky", h0, 1);
        clear();
        dbg_addr = 3'd6;
        #1;
        check("halted_wb", d0, 16'h0606);
        reset = 1;
        step();
        clear();
        dbg_addr = 3'd3;
        #1;
        check("rst2_halted", h0, 0);
        check("rst2_dbg_r3", d0, 0);
        check("rst2_out_a", a0, 0);
        in_valid = 1; in_ra = 3'd6;
        step();
        check("rst2_r6", a0, 0);
        check("rst2_valid", v0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
